// File: rtl/pattern_encoder.sv
// pattern_encoder: serial pattern store, replayed 1..15 times on sig_out.
// Start/busy/done handshake; pattern rotates so it survives each replay.
module pattern_encoder #(
  parameter int N  = 1024,
  parameter int CW = 11
) (
  input  logic       clk,
  input  logic       rnot,
  input  logic       prgm,
  input  logic       prgm_en,
  input  logic       start,
  input  logic [3:0] burst,
  output logic       sig_out,
  output logic       sig_valid,
  output logic       busy,
  output logic       done,
  output logic       loaded
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } st_t;

  localparam logic [CW-1:0] NC   = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  st_t           st;
  st_t           st_nx;
  logic [N-1:0]  pat;
  logic [CW-1:0] ld_cnt;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    reps;

  logic do_load;
  logic accept;
  logic sending;
  logic last;
  logic more;

  assign do_load = (st == S_IDLE) && prgm_en;
  assign accept  = (st == S_IDLE) && start
                && !prgm_en && loaded;
  assign sending = (st == S_SEND);
  assign last    = sending && (bit_cnt == LAST);
  assign more    = (reps > 4'd1);

  always_comb begin
    st_nx = st;
    unique case (st)
      S_IDLE:  if (accept) st_nx = S_SEND;
      S_SEND:  if (last && !more) st_nx = S_DONE;
      S_DONE:  st_nx = S_IDLE;
      default: st_nx = S_IDLE;
    endcase
  end

  assign sig_valid = sending;
  assign sig_out   = sending && pat[N-1];
  assign busy      = sending;
  assign done      = (st == S_DONE);

  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) begin
      st      <= S_IDLE;
      pat     <= '0;
      ld_cnt  <= '0;
      loaded  <= 1'b0;
      bit_cnt <= '0;
      reps    <= '0;
    end else begin
      st <= st_nx;
      unique case (1'b1)
        do_load: begin
          pat <= {pat[N-2:0], prgm};
          if (ld_cnt != NC)
            ld_cnt <= ld_cnt + CW'(1);
          loaded <= (ld_cnt >= LAST);
        end
        accept: begin
          reps    <= (burst == 4'd0) ? 4'd1 : burst;
          bit_cnt <= '0;
        end
        sending: begin
          pat <= {pat[N-2:0], pat[N-1]};
          if (last) begin
            bit_cnt <= '0;
            if (more)
              reps <= reps - 4'd1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_encoder.sv
// tb_pattern_encoder: table vectors, directed corners, random sends
// checked against a queue-based model, plus a loopback detector.
module tb_pattern_encoder;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rnot;
  logic       prgm;
  logic       prgm_en;
  logic       start;
  logic [3:0] burst;
  logic       sig_out;
  logic       sig_valid;
  logic       busy;
  logic       done;
  logic       loaded;

  int checks = 0;
  int errors = 0;

  bit m_q[$];
  int m_cnt;

  logic [N-1:0] det_prog;
  logic [N-1:0] det_win;
  logic         det_out;

  pattern_encoder #(.N(N), .CW(4)) dut (
    .clk       (clk),
    .rnot      (rnot),
    .prgm      (prgm),
    .prgm_en   (prgm_en),
    .start     (start),
    .burst     (burst),
    .sig_out   (sig_out),
    .sig_valid (sig_valid),
    .busy      (busy),
    .done      (done),
    .loaded    (loaded)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rnot) begin
    if (!rnot) begin
      det_win <= '0;
      det_out <= 1'b0;
    end else begin
      det_out <= sig_valid
              && ({det_win[N-2:0], sig_out} == det_prog);
      if (sig_valid)
        det_win <= {det_win[N-2:0], sig_out};
    end
  end

  task automatic chk(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(string nm);
    chk({nm, ".busy"}, busy, 1'b0);
    chk({nm, ".done"}, done, 1'b0);
    chk({nm, ".valid"}, sig_valid, 1'b0);
    chk({nm, ".out"}, sig_out, 1'b0);
  endtask

  function automatic void m_reset();
    m_q.delete();
    m_cnt = 0;
  endfunction

  function automatic void m_load(bit b);
    m_q.push_back(b);
    if (m_q.size() > N)
      void'(m_q.pop_front());
    m_cnt++;
  endfunction

  function automatic bit m_loaded();
    return m_cnt >= N;
  endfunction

  task automatic load(bit b);
    prgm_en = 1'b1;
    prgm    = b;
    @(negedge clk);
    prgm_en = 1'b0;
    m_load(b);
    chk("load.loaded", loaded, m_loaded());
  endtask

  task automatic send(int b, bit poke, bit chk_det);
    int reps;
    reps  = (b == 0) ? 1 : b;
    start = 1'b1;
    burst = 4'(b);
    @(negedge clk);
    start = 1'b0;
    burst = 4'($urandom_range(0, 15));
    for (int i = 0; i < reps * N; i++) begin
      chk("send.out", sig_out, m_q[i % N]);
      chk("send.valid", sig_valid, 1'b1);
      chk("send.busy", busy, 1'b1);
      chk("send.done", done, 1'b0);
      if (chk_det)
        chk("loop.det", det_out, i > 0 && i % N == 0);
      if (poke && i == 2) begin
        start   = 1'b1;
        prgm_en = 1'b1;
        prgm    = 1'($urandom_range(0, 1));
      end
      if (poke && i == 4) begin
        start   = 1'b0;
        prgm_en = 1'b0;
      end
      @(negedge clk);
    end
    chk("fin.done", done, 1'b1);
    chk("fin.busy", busy, 1'b0);
    chk("fin.valid", sig_valid, 1'b0);
    chk("fin.out", sig_out, 1'b0);
    if (chk_det)
      chk("loop.det_last", det_out, 1'b1);
    @(negedge clk);
    chk_idle("post");
    chk("post.loaded", loaded, 1'b1);
  endtask

  typedef struct {
    bit b;
    bit ld;
  } ld_vec_t;

  ld_vec_t vec[8];

  initial begin
    vec[0] = '{1'b1, 1'b0};
    vec[1] = '{1'b0, 1'b0};
    vec[2] = '{1'b1, 1'b0};
    vec[3] = '{1'b1, 1'b0};
    vec[4] = '{1'b0, 1'b0};
    vec[5] = '{1'b0, 1'b0};
    vec[6] = '{1'b1, 1'b0};
    vec[7] = '{1'b0, 1'b1};
    det_prog = 8'b10110010;

    rnot    = 1'b0;
    prgm    = 1'b0;
    prgm_en = 1'b0;
    start   = 1'b0;
    burst   = 4'd0;
    m_reset();
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst.loaded", loaded, 1'b0);
    rnot = 1'b1;
    @(negedge clk);

    start = 1'b1;
    burst = 4'd2;
    repeat (3) begin
      @(negedge clk);
      chk_idle("unloaded");
    end
    start = 1'b0;

    for (int i = 0; i < 8; i++) begin
      prgm_en = 1'b1;
      prgm    = vec[i].b;
      @(negedge clk);
      prgm_en = 1'b0;
      m_load(vec[i].b);
      chk("vec.loaded", loaded, vec[i].ld);
    end

    send(1, 1'b0, 1'b0);
    send(3, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0);
    send(1, 1'b1, 1'b0);
    send(2, 1'b0, 1'b1);

    start   = 1'b1;
    prgm_en = 1'b1;
    prgm    = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    prgm_en = 1'b0;
    m_load(1'b1);
    chk_idle("start_load");
    @(negedge clk);
    chk_idle("start_load2");
    send(1, 1'b0, 1'b0);

    start = 1'b1;
    burst = 4'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rnot = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst.loaded", loaded, 1'b0);
    @(negedge clk);
    rnot = 1'b1;
    m_reset();
    start = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_idle("arst.ign");
    end
    start = 1'b0;
    for (int i = 0; i < N; i++)
      load(1'($urandom_range(0, 1)));
    send(2, 1'b0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      int nb;
      nb = $urandom_range(0, 10);
      for (int k = 0; k < nb; k++)
        load(1'($urandom_range(0, 1)));
      if (m_loaded()) begin
        send(int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'b0);
      end else begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_idle("rnd.ign");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
